// File: rtl/nfc_buf_pkg.sv
// ============================================================================
// nfc_buf_pkg : shared types and constants for the NFC ping-pong page buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package nfc_buf_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        READY    = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int c_dflt_data_width = 16;
    localparam int c_dflt_page_depth = 2048;
    localparam int c_dflt_num_banks  = 2;

    localparam logic c_dir_program = 1'b0;
    localparam logic c_dir_read    = 1'b1;

endpackage : nfc_buf_pkg

`default_nettype wire

// File: rtl/nfc_buf_ram.sv
// ============================================================================
// nfc_buf_ram : simple dual-port page RAM, one write port, registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module nfc_buf_ram
    import nfc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = c_dflt_data_width,
    parameter int DEPTH      = c_dflt_num_banks * c_dflt_page_depth,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : nfc_buf_ram

`default_nettype wire

// File: rtl/nfc_pingpong_buf.sv
// ============================================================================
// nfc_pingpong_buf : multi-bank ping-pong page buffer, host <-> NAND core
// Rev 1.0
// ============================================================================
`default_nettype none

module nfc_pingpong_buf
    import nfc_buf_pkg::*;
#(
    parameter int DATA_WIDTH = c_dflt_data_width,
    parameter int PAGE_DEPTH = c_dflt_page_depth,
    parameter int NUM_BANKS  = c_dflt_num_banks,
    parameter int ADDR_W     = $clog2(PAGE_DEPTH),
    parameter int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dir,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  host_wr_en,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_rd_en,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  host_ready,
    output logic                  host_done,
    input  logic                  cntrl_wr_en,
    input  logic [DATA_WIDTH-1:0] cntrl_wdata,
    input  logic                  cntrl_rd_en,
    output logic [DATA_WIDTH-1:0] cntrl_rdata,
    output logic                  cntrl_rvalid,
    output logic                  cntrl_ready,
    output logic                  cntrl_done,
    output logic [BANK_W:0]       full_cnt,
    output logic                  err
);

    localparam logic [ADDR_W-1:0] c_last_off = ADDR_W'(PAGE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_off_one  = ADDR_W'(1);
    localparam logic [BANK_W-1:0] c_bank_one = BANK_W'(1);
    localparam logic [BANK_W:0]   c_cnt_one  = (BANK_W + 1)'(1);

    bank_state_t           r_state [NUM_BANKS];
    logic [BANK_W-1:0]     r_prod_bank;
    logic [BANK_W-1:0]     r_cons_bank;
    logic [ADDR_W-1:0]     r_prod_off;
    logic [ADDR_W-1:0]     r_cons_off;
    logic                  r_dir;
    logic                  r_err;
    logic                  r_host_rvalid;
    logic                  r_cntrl_rvalid;
    logic                  r_host_done;
    logic                  r_cntrl_done;
    logic                  r_rd_host;

    logic                  w_all_free;
    logic [BANK_W:0]       w_full_cnt;
    logic                  w_dir;
    logic                  w_prog;
    logic                  w_prod_en;
    logic [DATA_WIDTH-1:0] w_prod_data;
    logic                  w_cons_en;
    logic                  w_prod_ready;
    logic                  w_cons_ready;
    logic                  w_prod_fire;
    logic                  w_cons_fire;
    logic                  w_prod_last;
    logic                  w_cons_last;
    logic                  w_err_set;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    always_comb begin
        w_all_free = 1'b1;
        w_full_cnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_state[b] != FREE) begin
                w_all_free = 1'b0;
            end
            if (r_state[b] == READY) begin
                w_full_cnt = w_full_cnt + c_cnt_one;
            end
        end
    end

    // A new direction is only adopted while every bank is empty.
    assign w_dir  = w_all_free ? dir : r_dir;
    assign w_prog = (w_dir == c_dir_program);

    assign w_prod_en   = w_prog ? host_wr_en  : cntrl_wr_en;
    assign w_prod_data = w_prog ? host_wdata  : cntrl_wdata;
    assign w_cons_en   = w_prog ? cntrl_rd_en : host_rd_en;

    assign w_prod_ready = (r_state[r_prod_bank] == FREE)  || (r_state[r_prod_bank] == FILLING);
    assign w_cons_ready = (r_state[r_cons_bank] == READY) || (r_state[r_cons_bank] == DRAINING);

    assign w_prod_fire = w_prod_en & w_prod_ready & ~flush;
    assign w_cons_fire = w_cons_en & w_cons_ready & ~flush;
    assign w_prod_last = (r_prod_off == c_last_off);
    assign w_cons_last = (r_cons_off == c_last_off);

    assign w_err_set = ~flush & ((w_prod_en & ~w_prod_ready)
                               | (w_cons_en & ~w_cons_ready)
                               | ((dir != r_dir) & ~w_all_free)
                               | (host_wr_en & host_rd_en)
                               | (cntrl_wr_en & cntrl_rd_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= FREE;
            end
            r_prod_bank    <= '0;
            r_cons_bank    <= '0;
            r_prod_off     <= '0;
            r_cons_off     <= '0;
            r_dir          <= c_dir_program;
            r_err          <= 1'b0;
            r_host_rvalid  <= 1'b0;
            r_cntrl_rvalid <= 1'b0;
            r_host_done    <= 1'b0;
            r_cntrl_done   <= 1'b0;
            r_rd_host      <= 1'b0;
        end else begin
            r_host_rvalid  <= w_cons_fire & ~w_prog;
            r_cntrl_rvalid <= w_cons_fire &  w_prog;
            r_host_done    <= w_prog ? (w_prod_fire & w_prod_last) : (w_cons_fire & w_cons_last);
            r_cntrl_done   <= w_prog ? (w_cons_fire & w_cons_last) : (w_prod_fire & w_prod_last);

            if (w_cons_fire) begin
                r_rd_host <= ~w_prog;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (w_all_free) begin
                r_dir <= dir;
            end

            if (flush) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    r_state[b] <= FREE;
                end
                r_prod_bank <= '0;
                r_cons_bank <= '0;
                r_prod_off  <= '0;
                r_cons_off  <= '0;
            end else begin
                // Producer and consumer can never target the same bank here,
                // since their ready conditions need disjoint bank states.
                if (w_prod_fire) begin
                    r_state[r_prod_bank] <= w_prod_last ? READY : FILLING;
                    r_prod_off           <= w_prod_last ? '0 : r_prod_off + c_off_one;
                    if (w_prod_last) begin
                        r_prod_bank <= r_prod_bank + c_bank_one;
                    end
                end
                if (w_cons_fire) begin
                    r_state[r_cons_bank] <= w_cons_last ? FREE : DRAINING;
                    r_cons_off           <= w_cons_last ? '0 : r_cons_off + c_off_one;
                    if (w_cons_last) begin
                        r_cons_bank <= r_cons_bank + c_bank_one;
                    end
                end
            end
        end
    end

    nfc_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_BANKS * PAGE_DEPTH),
        .ADDR_W     (BANK_W + ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_prod_fire),
        .waddr ({r_prod_bank, r_prod_off}),
        .wdata (w_prod_data),
        .re    (w_cons_fire),
        .raddr ({r_cons_bank, r_cons_off}),
        .rdata (w_ram_rdata)
    );

    assign host_rdata   = r_rd_host ? w_ram_rdata : '0;
    assign cntrl_rdata  = r_rd_host ? '0 : w_ram_rdata;
    assign host_rvalid  = r_host_rvalid;
    assign cntrl_rvalid = r_cntrl_rvalid;
    assign host_done    = r_host_done;
    assign cntrl_done   = r_cntrl_done;
    assign host_ready   = w_prog ? w_prod_ready : w_cons_ready;
    assign cntrl_ready  = w_prog ? w_cons_ready : w_prod_ready;
    assign full_cnt     = w_full_cnt;
    assign err          = r_err;

endmodule : nfc_pingpong_buf

`default_nettype wire

// File: tb/tb_nfc_pingpong_buf.sv
// ============================================================================
// tb_nfc_pingpong_buf : bench for the ping-pong page buffer (2- and 4-bank)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nfc_pingpong_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 2 banks of 8 words
    logic        a_dir = 0, a_flush = 0, a_err_clr = 0;
    logic        a_hwr = 0, a_hrd = 0, a_cwr = 0, a_crd = 0;
    logic [15:0] a_hwd = 0, a_cwd = 0, a_hrdata, a_crdata;
    logic        a_hrv, a_crv, a_hready, a_cready, a_hdone, a_cdone, a_err;
    logic [1:0]  a_full;

    // DUT B: 4 banks of 8 words, read flow
    logic        b_dir = 1, b_flush = 0, b_err_clr = 0;
    logic        b_hwr = 0, b_hrd = 0, b_cwr = 0, b_crd = 0;
    logic [15:0] b_hwd = 0, b_cwd = 0, b_hrdata, b_crdata;
    logic        b_hrv, b_crv, b_hready, b_cready, b_hdone, b_cdone, b_err;
    logic [2:0]  b_full;

    nfc_pingpong_buf #(.DATA_WIDTH(16), .PAGE_DEPTH(8), .NUM_BANKS(2)) u_dut_a (
        .clk(clk), .rst(rst), .dir(a_dir), .flush(a_flush), .err_clr(a_err_clr),
        .host_wr_en(a_hwr), .host_wdata(a_hwd), .host_rd_en(a_hrd),
        .host_rdata(a_hrdata), .host_rvalid(a_hrv), .host_ready(a_hready), .host_done(a_hdone),
        .cntrl_wr_en(a_cwr), .cntrl_wdata(a_cwd), .cntrl_rd_en(a_crd),
        .cntrl_rdata(a_crdata), .cntrl_rvalid(a_crv), .cntrl_ready(a_cready), .cntrl_done(a_cdone),
        .full_cnt(a_full), .err(a_err)
    );

    nfc_pingpong_buf #(.DATA_WIDTH(16), .PAGE_DEPTH(8), .NUM_BANKS(4)) u_dut_b (
        .clk(clk), .rst(rst), .dir(b_dir), .flush(b_flush), .err_clr(b_err_clr),
        .host_wr_en(b_hwr), .host_wdata(b_hwd), .host_rd_en(b_hrd),
        .host_rdata(b_hrdata), .host_rvalid(b_hrv), .host_ready(b_hready), .host_done(b_hdone),
        .cntrl_wr_en(b_cwr), .cntrl_wdata(b_cwd), .cntrl_rd_en(b_crd),
        .cntrl_rdata(b_crdata), .cntrl_rvalid(b_crv), .cntrl_ready(b_cready), .cntrl_done(b_cdone),
        .full_cnt(b_full), .err(b_err)
    );

    typedef struct packed {
        logic        is_host;
        logic [15:0] data;
        logic        done;
    } exp_t;

    typedef struct {
        logic        hw;
        logic [15:0] hd;
        logic        cr;
        logic        ex_hr;
        logic        ex_cr;
        logic        ex_hd;
        logic [1:0]  ex_full;
        logic        ex_err;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    vec_t tbl [16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
            tick();
            k++;
        end
        chk("drain_pending", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic check_reset();
        chk("a_reset", {a_hready, a_cready, a_hrv, a_crv, a_hdone, a_cdone, a_err, a_full, a_hrdata, a_crdata},
                       {1'b1, 1'b0, 5'b0, 2'b0, 32'b0});
        chk("b_reset", {b_hready, b_cready, b_hrv, b_crv, b_hdone, b_cdone, b_err, b_full, b_hrdata, b_crdata},
                       {1'b0, 1'b1, 5'b0, 3'b0, 32'b0});
    endtask

    // Scoreboard monitors: every rvalid must match the oldest queued read
    always @(negedge clk) begin
        if (a_hrv && a_crv) begin
            chk("a_rvalid_both", 64'd1, 64'd0);
        end else if (a_hrv || a_crv) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_read", {a_hrv, (a_hrv ? a_hrdata : a_crdata), (a_hrv ? a_hdone : a_cdone)},
                              {ea.is_host, ea.data, ea.done});
            end
        end
    end

    always @(negedge clk) begin
        if (b_hrv && b_crv) begin
            chk("b_rvalid_both", 64'd1, 64'd0);
        end else if (b_hrv || b_crv) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_read", {b_hrv, (b_hrv ? b_hrdata : b_crdata), (b_hrv ? b_hdone : b_cdone)},
                              {eb.is_host, eb.data, eb.done});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        // Vector table: one page written by the host, then drained by the controller
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{hw: 1'b1, hd: 16'(i), cr: 1'b0, ex_hr: 1'b1, ex_cr: (i == 7),
                       ex_hd: (i == 7), ex_full: ((i == 7) ? 2'd1 : 2'd0), ex_err: 1'b0};
            tbl[8+i] = '{hw: 1'b0, hd: 16'd0, cr: 1'b1, ex_hr: 1'b1, ex_cr: (i != 7),
                         ex_hd: 1'b0, ex_full: 2'd0, ex_err: 1'b0};
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();

        for (int i = 0; i < 16; i++) begin
            a_hwr = tbl[i].hw;
            a_hwd = tbl[i].hd;
            a_crd = tbl[i].cr;
            if (tbl[i].cr) qa.push_back('{1'b0, 16'(i - 8), (i == 15)});
            tick();
            a_hwr = 1'b0;
            a_crd = 1'b0;
            chk($sformatf("vec%0d", i), {a_hready, a_cready, a_hdone, a_full, a_err},
                {tbl[i].ex_hr, tbl[i].ex_cr, tbl[i].ex_hd, tbl[i].ex_full, tbl[i].ex_err});
        end
        drain();

        // Ping-pong: host writes 16 words, controller drains from the 9th cycle
        for (int c = 0; c < 24; c++) begin
            a_hwr = (c < 16);
            a_hwd = 16'h0100 + 16'(c);
            a_crd = (c >= 8);
            if (c < 16) chk("pp_host_ready", 64'(a_hready), 64'd1);
            if (c >= 8) begin
                chk("pp_cntrl_ready", 64'(a_cready), 64'd1);
                qa.push_back('{1'b0, 16'h0100 + 16'(c - 8), ((c - 8) % 8 == 7)});
            end
            tick();
        end
        a_hwr = 1'b0;
        a_crd = 1'b0;
        drain();

        // Full / overflow / underflow
        for (int i = 0; i < 16; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0200 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        chk("full_state", {a_hready, a_cready, a_full, a_err}, {1'b0, 1'b1, 2'd2, 1'b0});
        a_hwr = 1'b1;
        a_hwd = 16'hDEAD;
        tick();
        a_hwr = 1'b0;
        chk("overflow_err", {a_err, a_full}, {1'b1, 2'd2});
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        chk("err_clr_1", 64'(a_err), 64'd0);
        for (int i = 0; i < 16; i++) begin
            a_crd = 1'b1;
            qa.push_back('{1'b0, 16'h0200 + 16'(i), (i % 8 == 7)});
            tick();
        end
        a_crd = 1'b0;
        drain();
        chk("empty_state", {a_hready, a_cready, a_full}, {1'b1, 1'b0, 2'd0});
        a_crd = 1'b1;
        tick();
        a_crd = 1'b0;
        chk("underflow_err", 64'(a_err), 64'd1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;

        // Read flow on 4 banks: controller fills four pages, host drains them
        for (int i = 0; i < 32; i++) begin
            chk("b_fill_ready", 64'(b_cready), 64'd1);
            b_cwr = 1'b1;
            b_cwd = 16'h0100 + 16'(i);
            tick();
        end
        b_cwr = 1'b0;
        chk("b_full_state", {b_cready, b_hready, b_full}, {1'b0, 1'b1, 3'd4});
        for (int i = 0; i < 32; i++) begin
            chk("b_drain_ready", 64'(b_hready), 64'd1);
            b_hrd = 1'b1;
            qb.push_back('{1'b1, 16'h0100 + 16'(i), (i % 8 == 7)});
            tick();
        end
        b_hrd = 1'b0;
        drain();
        chk("b_empty_state", {b_hready, b_cready, b_full, b_err}, {1'b0, 1'b1, 3'd0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            b_cwr = 1'b1;
            b_cwd = 16'h0300 + 16'(i);
            tick();
        end
        b_cwr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_hrd = 1'b1;
            qb.push_back('{1'b1, 16'h0300 + 16'(i), (i == 7)});
            tick();
        end
        b_hrd = 1'b0;
        drain();

        // Direction change while a bank is filling
        for (int i = 0; i < 3; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0400 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        a_dir = 1'b1;
        tick();
        chk("dir_err", {a_err, a_hready, a_cready}, {1'b1, 1'b1, 1'b0});
        for (int i = 3; i < 8; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0400 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_crd = 1'b1;
            qa.push_back('{1'b0, 16'h0400 + 16'(i), (i == 7)});
            tick();
        end
        a_crd = 1'b0;
        drain();
        chk("dir_taken", {a_hready, a_cready}, {1'b0, 1'b1});
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        chk("err_clr_2", 64'(a_err), 64'd0);
        a_dir = 1'b0;
        tick();
        chk("dir_back", {a_err, a_hready, a_cready}, {1'b0, 1'b1, 1'b0});

        // Flush of a full page
        for (int i = 0; i < 8; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0600 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("flush_state", {a_full, a_cready, a_hready}, {2'd0, 1'b0, 1'b1});

        // Reset in the middle of a page fill
        for (int i = 0; i < 5; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0700 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();
        for (int i = 0; i < 8; i++) begin
            a_hwr = 1'b1;
            a_hwd = 16'h0500 + 16'(i);
            tick();
        end
        a_hwr = 1'b0;
        chk("post_reset_full", 64'(a_full), 64'd1);
        for (int i = 0; i < 8; i++) begin
            a_crd = 1'b1;
            qa.push_back('{1'b0, 16'h0500 + 16'(i), (i == 7)});
            tick();
        end
        a_crd = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_nfc_pingpong_buf

`default_nettype wire

// File: doc/nfc_pingpong_buf.md
# nfc_pingpong_buf

Parametrised multi-bank page buffer between the host interface and the NAND flash controller core, replacing the single-page buffer. Banks of one page each are filled by one side and drained by the other in round-robin order, so the host can load page N+1 while the controller programs page N. A direction input selects program flow (host fills, controller drains) or read flow (controller fills, host drains). Per-bank ownership, word counters and completion status are handled internally.

## Interface
- DATA_WIDTH, 16: word width.
- PAGE_DEPTH, 2048: words per bank; power of two, at least 4.
- NUM_BANKS, 2: bank count; power of two, 2 to 8.
- ADDR_W, $clog2(PAGE_DEPTH): derived; offset width.
- BANK_W, $clog2(NUM_BANKS): derived; bank index width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dir  in  1  0 = program (host produces, controller consumes); 1 = read (controller produces, host consumes).
- flush  in  1  synchronous abort; all banks return to FREE.
- err_clr  in  1  clears err.
- host_wr_en  in  1  host write strobe; acted on only when dir=0.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rd_en  in  1  host read strobe; acted on only when dir=1.
- host_rdata  out  DATA_WIDTH  host read data.
- host_rvalid  out  1  host_rdata valid.
- host_ready  out  1  host side may issue an access this cycle.
- host_done  out  1  one-cycle pulse when the host finishes a page.
- cntrl_wr_en, cntrl_wdata, cntrl_rd_en, cntrl_rdata, cntrl_rvalid, cntrl_ready, cntrl_done: controller-side mirrors of the host ports above, with dir polarity inverted.
- full_cnt  out  BANK_W+1  number of banks in READY.
- err  out  1  sticky protocol error.

## Operation
- Bank states:
  - FREE -> FILLING on the first producer write.
  - FILLING -> READY on the producer's PAGE_DEPTH-th write.
  - READY -> DRAINING on the first consumer read.
  - DRAINING -> FREE on the PAGE_DEPTH-th consumer read.
- Producer side:
  - Holds a bank pointer and an offset counter.
  - Ready when the bank at its pointer is FREE or FILLING.
  - Each write stores at {prod_bank, prod_off} and increments the offset.
  - On offset PAGE_DEPTH-1 the offset wraps to 0 and the pointer advances modulo NUM_BANKS.
- Consumer side:
  - Same pointer and counter structure.
  - Ready when the bank at its pointer is READY or DRAINING.
  - After its last read, the consumer side pulses done.
- Mapping: producer side = host when dir=0, controller when dir=1; the consumer side is the other one.
- Strobes on the inactive port of a side are ignored and have no effect.
- err is set by any of:
  - producer or consumer strobe while that side is not ready (access dropped; no state change);
  - dir change while any bank is not FREE (the new dir is ignored until all banks are FREE);
  - host_wr_en and host_rd_en asserted together on one side.
- flush: all banks FREE, all pointers and offsets 0, pending rvalid suppressed, err unchanged.
- rst: same effect as flush, plus err=0.

## Timing
- Reset values:
  - host_rdata, cntrl_rdata = 0.
  - host_rvalid, cntrl_rvalid, host_done, cntrl_done, full_cnt, err = 0.
  - host_ready = ~dir; cntrl_ready = dir.
- Write: the strobe in cycle t is stored at the edge ending t. A read of that address is legal from t+1.
- Read latency 1: rd_en in cycle t gives rdata and rvalid in t+1.
- done pulses in the same cycle as the final rvalid.
- ready outputs and full_cnt are functions of registered state only; there is no combinational path from strobes.
- Bank hand-offs are visible to the other side one cycle later:
  - a bank that becomes READY at the end of cycle t can be read from t+1;
  - a bank freed at the end of cycle t can be written from t+1.
- A producer and consumer on different banks run concurrently at one word per cycle each, with no stalls.
- With all banks READY, producer ready=0 (full). With all banks FREE, consumer ready=0 (empty).
- flush takes priority over strobes in the same cycle.

## Structure
- Package nfc_buf_pkg holds the bank_state_t enum (FREE, FILLING, READY, DRAINING), the default parameter constants, and the dir encoding constants.
- Sub-module nfc_buf_ram: simple dual-port RAM, one write port and one registered read port, NUM_BANKS*PAGE_DEPTH x DATA_WIDTH, address {bank, offset}.
- Top level holds the bank state array, the two pointer/offset counters, the side-mapping muxes and the error logic.

## Test plan
- PAGE_DEPTH=8, NUM_BANKS=2, dir=0:
  - host writes 0..7 -> full_cnt=1, cntrl_ready=1 at the next cycle;
  - controller reads 8 words -> rdata 0..7 at latency 1, cntrl_done pulses with the 8th rvalid.
- Ping-pong: host writes 16 words back to back while the controller drains from cycle 9 -> no stalls, host_ready stays 1, the controller sees 0..15 in order.
- Full/empty:
  - host writes 16 words with no reads -> host_ready=0, full_cnt=2;
  - a 17th write sets err and no data is corrupted;
  - a read with empty banks sets err.
- dir=1 with NUM_BANKS=4: controller fills 4 pages with 0x0100+i -> the host drains all 32 words correctly; pointers wrap back to bank 0.
- dir toggled while a bank is FILLING -> err=1, dir ignored; after drain the dir change takes effect; err_clr -> err=0.
- Reset mid-fill after 5 writes -> all outputs at reset values; the next page starts at bank 0, offset 0.
